// File: rtl/wirein_sync_pkg.sv
// Shared types and limits for the wire-in synchroniser bank.
package wirein_sync_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam int CNT_W      = 8;
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int STABLE_MIN = 1;
  localparam int STABLE_MAX = 255;
endpackage

// File: rtl/wirein_sync_chan.sv
// One wire-in channel: multi-flop synchroniser, stability filter FSM and
// registered commit/strobe outputs.
module wirein_sync_chan
  import wirein_sync_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic             freeze_i,
  output logic [WIDTH-1:0] data_o,
  output logic             changed_o,
  output logic [WIDTH-1:0] pulse_o
);
  localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chg_d   = 1'b0;
    pulse_d = '0;
    case (state_q)
      IDLE: begin
        if (sync != data_q) begin
          state_d = SETTLE;
          cand_d  = sync;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (sync == data_q) begin
          state_d = IDLE;
        end else if (sync != cand_q) begin
          cand_d = sync;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q < STB) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!freeze_i) begin
          // Counter sits saturated while frozen; commit on first unfrozen edge.
          data_d  = cand_q;
          chg_d   = 1'b1;
          pulse_d = cand_q & ~data_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chg_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chg_q   <= chg_d;
      pulse_q <= pulse_d;
    end
  end

  assign data_o    = data_q;
  assign changed_o = chg_q;
  assign pulse_o   = pulse_q;
endmodule

// File: rtl/wirein_sync_bank.sv
// Bank of independent wire-in channels crossing from the host domain into clk,
// each committing only after its value has held steady.
module wirein_sync_bank
  import wirein_sync_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] raw_in,
  input  logic                      freeze,
  output logic [CHANNELS*WIDTH-1:0] ep_dataout,
  output logic [CHANNELS-1:0]       ep_changed,
  output logic [CHANNELS*WIDTH-1:0] ep_pulse
);
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("wirein_sync_bank: SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
    $error("wirein_sync_bank: STABLE_CYCLES out of range");
  end
  if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_size
    $error("wirein_sync_bank: WIDTH and CHANNELS must be positive");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    wirein_sync_chan #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_in[c*WIDTH +: WIDTH]),
      .freeze_i (freeze),
      .data_o   (ep_dataout[c*WIDTH +: WIDTH]),
      .changed_o(ep_changed[c]),
      .pulse_o  (ep_pulse[c*WIDTH +: WIDTH])
    );
  end
endmodule
